mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative HI/LO multiply/divide unit for the MIPS datapath, sitting directly downstream of the register file. It consumes the two register-file read ports (rs, rt) for MULT, MULTU, DIV and DIVU. Results accumulate over 33 cycles into architectural HI/LO registers, which MFHI/MFLO read and MTHI/MTLO write. A start/busy/done handshake lets the control unit stall HI/LO accesses until the result is valid.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- start  in  1  one-cycle request; sampled only while busy=0.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- rs_data  in  32  operand A / dividend (register-file ReadData1).
- rt_data  in  32  operand B / divisor (register-file ReadData2).
- hi_we  in  1  MTHI: write wdata into HI.
- lo_we  in  1  MTLO: write wdata into LO.
- wdata  in  32  MTHI/MTLO data.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; HI/LO are updated on the same edge.
- hi  out  32  HI register (MFHI source).
- lo  out  32  LO register (MFLO source).

## Operation
- States: IDLE, CALC, FIX.
- IDLE with start=1:
  - latch op and the absolute values of rs_data/rt_data (raw values for unsigned ops);
  - latch the result sign flags;
  - clear the iteration counter (6 bits); go to CALC.
- CALC: one iteration per cycle for 32 cycles (counter 0..31); go to FIX after the iteration with counter=31.
  - Multiply: unsigned shift-add on magnitudes into a 64-bit product.
  - Divide: restoring shift-subtract on magnitudes; 32-bit quotient and remainder.
- FIX: apply sign correction, write HI/LO, pulse done, return to IDLE.
  - MULT: negate the 64-bit product when sign(rs)≠sign(rt); HI=product[63:32], LO=product[31:0].
  - DIV: LO=quotient, negated when sign(rs)≠sign(rt). HI=remainder, negated when rs is negative, so the remainder takes the sign of the dividend.
  - Unsigned ops: no correction.
- Divide by zero (DIV or DIVU with rt_data=0): full latency; LO=32'hFFFFFFFF, HI=rs_data as originally presented, no sign correction.
- DIV 32'h80000000 / 32'hFFFFFFFF: LO=32'h80000000, HI=0 (wraps, no trap).
- Operands are captured at start. Register-file outputs may change freely after the accepting edge.
- start while busy=1: ignored (no queueing).
- hi_we/lo_we:
  - honoured only in IDLE with start=0;
  - ignored while busy, and ignored in the cycle start is accepted (start has priority);
  - hi_we and lo_we together write both registers.
- reset (any state, including mid-CALC):
  - state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0;
  - the in-flight operation is discarded.

## Timing
- Reset values: busy=0, done=0, hi=32'h0, lo=32'h0.
- Edge E0 accepts start; busy=1 from after E0.
- Edges E1..E32 perform the 32 iterations.
- Edge E33 performs FIX:
  - hi/lo take their new values;
  - done=1 for the single cycle after E33;
  - busy=0 after E33.
- Latency from start to done: 33 cycles. busy is high for exactly 33 cycles.
- A new start may be asserted in the same cycle done is high; it is accepted at the next edge.
- hi/lo hold their previous values throughout CALC; there are no intermediate results.
- MTHI/MTLO: the value appears on hi/lo one cycle after the write edge.

## Test plan
- MULT rs=32'hFFFFFFFD (-3), rt=7 -> after 33 cycles done pulses; HI=32'hFFFFFFFF, LO=32'hFFFFFFEB; busy high exactly 33 cycles.
- MULTU rs=rt=32'hFFFFFFFF -> HI=32'hFFFFFFFE, LO=32'h00000001. Then MULT with the same operands -> HI=0, LO=1.
- DIV rs=32'hFFFFFFF9 (-7), rt=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. DIV 32'h80000000/32'hFFFFFFFF -> LO=32'h80000000, HI=0.
- DIVU rs=7, rt=0 -> LO=32'hFFFFFFFF, HI=7 after 33 cycles. DIVU 100/7 -> LO=14, HI=2.
- Start MULT 5×6, assert reset at cycle 10 -> busy=0, done never pulses, hi=lo=0. Then a new MULT 5×6 -> LO=30.
- While busy, pulse start (DIVU 9/3) and hi_we with wdata=32'hDEAD -> both ignored; the original result lands. In IDLE, hi_we with wdata=32'hDEAD -> hi=32'hDEAD next cycle, lo unchanged.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32x32 multiply / 32/32 divide feeding the HI/LO
// registers. The unit takes 33 cycles per operation (32 iterations plus one
// sign-fix cycle). MTHI/MTLO writes are accepted only while the unit is idle.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO writes honoured here
// CALC  | one shift-add or shift-subtract iteration per cycle (32 cycles)
// FIX   | sign correction, HI/LO update, done pulse
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic        is_div;
    logic        neg_main;   // negate product / quotient
    logic        neg_rem;    // negate remainder (dividend was negative)
    logic        div_zero;
    logic [31:0] b_mag;      // multiplicand or divisor magnitude
    // Multiply: {partial product high, multiplier shifting out}.
    // Divide:   {remainder, dividend shifting out / quotient shifting in}.
    logic [63:0] acc;

    logic        signed_op;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    // Operand magnitudes at start; unsigned ops pass raw values through.
    assign signed_op = ~op[0];
    assign a_abs = (signed_op && rs_data[31]) ? (32'd0 - rs_data) : rs_data;
    assign b_abs = (signed_op && rt_data[31]) ? (32'd0 - rt_data) : rt_data;

    // Single iteration of unsigned shift-add multiply.
    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_mag} : 33'd0);
    assign mul_next = {mul_sum, acc[31:1]};

    // Single iteration of restoring divide. A zero divisor never restores,
    // so the quotient fills with ones and the remainder ends up as |rs|.
    assign div_shift = {acc[63:32], acc[31]};
    assign div_diff  = div_shift - {1'b0, b_mag};
    assign div_next  = div_diff[32] ? {div_shift[31:0], acc[30:0], 1'b0}
                                    : {div_diff[31:0],  acc[30:0], 1'b1};

    // Final sign correction. On divide-by-zero the remainder negation restores
    // the original signed dividend, and the all-ones quotient is left alone.
    assign prod_fix = neg_main ? (64'd0 - acc) : acc;
    assign quot_fix = (neg_main && !div_zero) ? (32'd0 - acc[31:0]) : acc[31:0];
    assign rem_fix  = neg_rem ? (32'd0 - acc[63:32]) : acc[63:32];

    // Sequencer, datapath iteration and HI/LO architectural registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 6'd0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            b_mag    <= 32'd0;
            acc      <= 64'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div   <= op[1];
                        neg_main <= signed_op && (rs_data[31] ^ rt_data[31]);
                        neg_rem  <= signed_op && op[1] && rs_data[31];
                        div_zero <= op[1] && (rt_data == 32'd0);
                        b_mag    <= b_abs;
                        acc      <= {32'd0, a_abs};
                        cnt      <= 6'd0;
                        busy     <= 1'b1;
                        state    <= CALC;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                CALC: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end else begin
                        hi <= prod_fix[63:32];
                        lo <= prod_fix[31:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: signed/unsigned multiply and divide,
// divide-by-zero, overflow divide, reset mid-operation, busy rejection,
// MTHI/MTLO writes and back-to-back starts.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int fails  = 0;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    mult_div_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Stimulus only: issue an op from #1 after an edge, scramble operands
    // after acceptance, and wait (bounded) for done.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, output int lat, output int bcnt);
        op = o; rs_data = a; rt_data = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rs_data = $urandom; rt_data = $urandom;
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
        end
    endtask

    task automatic test_reset;
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %h want 0", busy); end
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %h want 0", done); end
        checks++; if (hi !== 32'h0) begin fails++; $display("FAIL reset_hi got %h want 0", hi); end
        checks++; if (lo !== 32'h0) begin fails++; $display("FAIL reset_lo got %h want 0", lo); end
    endtask

    task automatic test_mult;
        int lat, bcnt;
        run_op(OP_MULT, 32'hFFFFFFFD, 32'd7, lat, bcnt);
        checks++; if (lat !== 33) begin fails++; $display("FAIL mult_latency got %0d want 33", lat); end
        checks++; if (bcnt !== 33) begin fails++; $display("FAIL mult_busy_cycles got %0d want 33", bcnt); end
        checks++; if (hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL mult_hi got %h want ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFEB) begin fails++; $display("FAIL mult_lo got %h want ffffffeb", lo); end
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt);
        checks++; if (hi !== 32'hFFFFFFFE) begin fails++; $display("FAIL multu_hi got %h want fffffffe", hi); end
        checks++; if (lo !== 32'h00000001) begin fails++; $display("FAIL multu_lo got %h want 1", lo); end
        run_op(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt);
        checks++; if (hi !== 32'h0) begin fails++; $display("FAIL mult_m1_hi got %h want 0", hi); end
        checks++; if (lo !== 32'h1) begin fails++; $display("FAIL mult_m1_lo got %h want 1", lo); end
    endtask

    task automatic test_div;
        int lat, bcnt;
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, lat, bcnt);
        checks++; if (lat !== 33) begin fails++; $display("FAIL div_latency got %0d want 33", lat); end
        checks++; if (lo !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_neg_lo got %h want fffffffd", lo); end
        checks++; if (hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL div_neg_hi got %h want ffffffff", hi); end
        run_op(OP_DIV, 32'd7, 32'hFFFFFFFE, lat, bcnt);
        checks++; if (lo !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_negdiv_lo got %h want fffffffd", lo); end
        checks++; if (hi !== 32'h1) begin fails++; $display("FAIL div_negdiv_hi got %h want 1", hi); end
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat, bcnt);
        checks++; if (lo !== 32'h80000000) begin fails++; $display("FAIL div_ovf_lo got %h want 80000000", lo); end
        checks++; if (hi !== 32'h0) begin fails++; $display("FAIL div_ovf_hi got %h want 0", hi); end
    endtask

    task automatic test_divu_and_zero;
        int lat, bcnt;
        run_op(OP_DIVU, 32'd7, 32'd0, lat, bcnt);
        checks++; if (lat !== 33) begin fails++; $display("FAIL divz_latency got %0d want 33", lat); end
        checks++; if (lo !== 32'hFFFFFFFF) begin fails++; $display("FAIL divuz_lo got %h want ffffffff", lo); end
        checks++; if (hi !== 32'd7) begin fails++; $display("FAIL divuz_hi got %h want 7", hi); end
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd0, lat, bcnt);
        checks++; if (lo !== 32'hFFFFFFFF) begin fails++; $display("FAIL divz_lo got %h want ffffffff", lo); end
        checks++; if (hi !== 32'hFFFFFFF9) begin fails++; $display("FAIL divz_hi got %h want fffffff9", hi); end
        run_op(OP_DIVU, 32'd100, 32'd7, lat, bcnt);
        checks++; if (lo !== 32'd14) begin fails++; $display("FAIL divu_lo got %h want e", lo); end
        checks++; if (hi !== 32'd2) begin fails++; $display("FAIL divu_hi got %h want 2", hi); end
    endtask

    task automatic test_reset_mid;
        int lat, bcnt, pulses;
        op = OP_MULT; rs_data = 32'd5; rt_data = 32'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        checks++; if (hi !== 32'd2 || lo !== 32'd14) begin
            fails++; $display("FAIL calc_hold got hi=%h lo=%h want hi=2 lo=e", hi, lo);
        end
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %h want 0", busy); end
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin
            fails++; $display("FAIL rstmid_hilo got hi=%h lo=%h want 0", hi, lo);
        end
        pulses = 0;
        repeat (40) begin @(posedge clk); #1; if (done) pulses++; end
        checks++; if (pulses !== 0) begin fails++; $display("FAIL rstmid_done got %0d pulses want 0", pulses); end
        run_op(OP_MULT, 32'd5, 32'd6, lat, bcnt);
        checks++; if (lo !== 32'd30 || hi !== 32'd0) begin
            fails++; $display("FAIL rstmid_rerun got hi=%h lo=%h want hi=0 lo=1e", hi, lo);
        end
    endtask

    task automatic test_busy_ignore;
        int lat;
        op = OP_DIVU; rs_data = 32'd100; rt_data = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        op = OP_DIVU; rs_data = 32'd9; rt_data = 32'd3; start = 1'b1;
        hi_we = 1'b1; wdata = 32'hDEAD;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0;
        checks++; if (hi !== 32'd0) begin fails++; $display("FAIL busy_mthi got %h want 0", hi); end
        lat = 0;
        while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
        checks++; if (lat !== 27) begin fails++; $display("FAIL busy_latency got %0d want 27", lat); end
        checks++; if (lo !== 32'd14 || hi !== 32'd2) begin
            fails++; $display("FAIL busy_result got hi=%h lo=%h want hi=2 lo=e", hi, lo);
        end
    endtask

    task automatic test_mthi_mtlo;
        int lat, bcnt;
        @(posedge clk); #1;
        hi_we = 1'b1; wdata = 32'hDEAD;
        @(posedge clk); #1;
        hi_we = 1'b0;
        checks++; if (hi !== 32'hDEAD) begin fails++; $display("FAIL mthi_hi got %h want dead", hi); end
        checks++; if (lo !== 32'd14) begin fails++; $display("FAIL mthi_lo got %h want e", lo); end
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        checks++; if (hi !== 32'h1234 || lo !== 32'h1234) begin
            fails++; $display("FAIL mtboth got hi=%h lo=%h want 1234", hi, lo);
        end
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hBEEF;
        op = OP_MULTU; rs_data = 32'd2; rt_data = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        checks++; if (hi !== 32'h1234 || lo !== 32'h1234) begin
            fails++; $display("FAIL start_prio got hi=%h lo=%h want 1234", hi, lo);
        end
        lat = 1;
        while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
        checks++; if (hi !== 32'd0 || lo !== 32'd6) begin
            fails++; $display("FAIL start_prio_result got hi=%h lo=%h want hi=0 lo=6", hi, lo);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bcnt;
        run_op(OP_MULTU, 32'd3, 32'd4, lat, bcnt);
        checks++; if (lo !== 32'd12) begin fails++; $display("FAIL b2b_first got %h want c", lo); end
        run_op(OP_DIVU, 32'd20, 32'd6, lat, bcnt);
        checks++; if (lat !== 33 || bcnt !== 33) begin
            fails++; $display("FAIL b2b_latency got lat=%0d busy=%0d want 33", lat, bcnt);
        end
        checks++; if (lo !== 32'd3 || hi !== 32'd2) begin
            fails++; $display("FAIL b2b_result got hi=%h lo=%h want hi=2 lo=3", hi, lo);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; rs_data = 32'd0; rt_data = 32'd0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        test_reset;
        test_mult;
        test_div;
        test_divu_and_zero;
        test_reset_mid;
        test_busy_ignore;
        test_mthi_mtlo;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
